// File: rtl/config_readback_tx_pkg.sv
// config_readback_tx shared types and constants.
// Frame layout and FSM state encodings for the config read-back path.
package config_readback_tx_pkg;

   localparam logic [7:0] HEADER        = 8'hA5;
   localparam int         NUM_CH        = 8;
   localparam int         DELAY_W       = 16;
   localparam int         READY_TIMEOUT = 1023;

   localparam int RB_FRAME_LEN   = 25;
   localparam int RB_PAYLOAD_LEN = 22;

   localparam logic [4:0] RB_LAST_IDX = 5'(RB_FRAME_LEN - 1);

   typedef enum logic [2:0] {
      RB_IDLE,
      RB_WAIT_RDY,
      RB_SEND,
      RB_WAIT_LOW,
      RB_WAIT_HIGH
   } rb_state_e;

   typedef struct packed {
      logic [7:0]                channel_select;
      logic [4:0]                aline_select;
      logic [31:0]               pulse_shape;
      logic [NUM_CH*DELAY_W-1:0] delays;
   } rb_cfg_t;

endpackage

// File: rtl/config_readback_tx_if.sv
// uart_transmit send/data/ready handshake.
// master drives the strobe and byte, slave reports idle.
interface config_readback_tx_if;

   logic       uart_send;
   logic [7:0] uart_data;
   logic       uart_ready;

   modport master (
      output uart_send,
      output uart_data,
      input  uart_ready
   );

   modport slave (
      input  uart_send,
      input  uart_data,
      output uart_ready
   );

endinterface

// File: rtl/config_readback_tx_byte_sel.sv
// Maps a frame byte index onto the snapshot config.
// Pure combinational; the checksum byte comes from the caller.
module config_readback_tx_byte_sel
   import config_readback_tx_pkg::*;
(
   input  rb_cfg_t    cfg,
   input  logic [4:0] idx,
   input  logic [7:0] csum,
   output logic [7:0] data
);

   logic [1:0] pb;
   logic [3:0] off;
   logic [6:0] dbit;

   // pulse bytes run MSB first; delay pairs are MSB then LSB per channel
   always_comb begin
      pb   = 2'(5'd7 - idx);
      off  = 4'(idx - 5'd8);
      dbit = {off[3:1], ~off[0], 3'b000};
   end

   always_comb begin
      data = 8'h00;
      unique case (1'b1)
         idx == 5'd0:
            data = HEADER;
         idx == 5'd1:
            data = 8'(RB_PAYLOAD_LEN);
         idx == 5'd2:
            data = cfg.channel_select;
         idx == 5'd3:
            data = {3'b000, cfg.aline_select};
         (idx >= 5'd4) && (idx <= 5'd7):
            data = cfg.pulse_shape[{pb, 3'b000} +: 8];
         (idx >= 5'd8) && (idx <= 5'd23):
            data = cfg.delays[dbit +: 8];
         idx == RB_LAST_IDX:
            data = csum;
         default:
            data = 8'h00;
      endcase
   end

endmodule

// File: rtl/config_readback_tx.sv
// Frames the snapshot imaging config onto uart_transmit.
// Waits for ready to fall then rise between strobes; times out if it never falls.
module config_readback_tx
   import config_readback_tx_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [7:0]                channel_select,
   input  logic [4:0]                aline_select,
   input  logic [31:0]               pulse_shape,
   input  logic [NUM_CH*DELAY_W-1:0] delays,
   config_readback_tx_if.master      uart,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   rb_state_e  state, state_n;
   rb_cfg_t    cfg;
   logic [4:0] idx;
   logic [7:0] csum;
   logic [9:0] tmo;
   logic       abort_q;
   logic [7:0] sel;
   logic       abort_hit;
   logic       last;
   logic       tmo_hit;

   config_readback_tx_byte_sel u_sel (
      .cfg  (cfg),
      .idx  (idx),
      .csum (csum),
      .data (sel)
   );

   assign abort_hit = abort_q | abort;
   assign last      = (idx == RB_LAST_IDX);
   assign tmo_hit   = (tmo == 10'(READY_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RB_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         RB_IDLE:
            if (start) state_n = RB_WAIT_RDY;
         RB_WAIT_RDY:
            if (uart.uart_ready) state_n = RB_SEND;
         RB_SEND:
            state_n = RB_WAIT_LOW;
         RB_WAIT_LOW:
            if (!uart.uart_ready) state_n = RB_WAIT_HIGH;
            else if (tmo_hit)     state_n = RB_IDLE;
         RB_WAIT_HIGH:
            if (uart.uart_ready)
               state_n = (abort_hit || last) ? RB_IDLE : RB_SEND;
         default:
            state_n = RB_IDLE;
      endcase
   end

   always_comb begin
      uart.uart_send = (state == RB_SEND);
      uart.uart_data = (state == RB_IDLE) ? 8'h00 : sel;
      busy           = (state != RB_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg     <= '0;
         idx     <= '0;
         csum    <= '0;
         tmo     <= '0;
         abort_q <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         done  <= (state == RB_WAIT_HIGH) && uart.uart_ready &&
                  !abort_hit && last;
         error <= (state == RB_WAIT_LOW) && uart.uart_ready && tmo_hit;
         if (state == RB_IDLE) begin
            abort_q <= 1'b0;
            if (start) begin
               cfg  <= '{channel_select, aline_select, pulse_shape, delays};
               idx  <= '0;
               csum <= '0;
            end
         end else if (abort) begin
            abort_q <= 1'b1;
         end
         if (state == RB_SEND) begin
            tmo <= '0;
            if ((idx >= 5'd1) && (idx <= 5'd23)) csum <= csum + sel;
         end else if (state == RB_WAIT_LOW) begin
            tmo <= tmo + 10'd1;
         end
         if ((state == RB_WAIT_HIGH) && (state_n == RB_SEND))
            idx <= idx + 5'd1;
      end
   end

endmodule

// File: tb/tb_config_readback_tx.sv
// Scoreboard bench for config_readback_tx.
// Reference frames are built from the byte layout; a monitor pops per strobe.
module tb_config_readback_tx;
   import config_readback_tx_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [7:0]   channel_select = '0;
   logic [4:0]   aline_select = '0;
   logic [31:0]  pulse_shape = '0;
   logic [127:0] delays = '0;
   logic         busy, done, error;

   config_readback_tx_if uart ();

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nstrobe = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int last_strobe = 0;
   int err_cyc = 0;
   bit stuck = 1'b0;
   logic [7:0] exp_q[$];

   config_readback_tx dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .channel_select (channel_select),
      .aline_select   (aline_select),
      .pulse_shape    (pulse_shape),
      .delays         (delays),
      .uart           (uart),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Reference frame: header, length, config fields, delays, byte-sum checksum
   function automatic void push_frame();
      logic [7:0] b[25];
      int sum = 0;
      b[0] = 8'hA5;
      b[1] = 8'd22;
      b[2] = channel_select;
      b[3] = {3'b000, aline_select};
      for (int i = 0; i < 4; i++) b[4+i] = 8'(pulse_shape >> (24 - 8*i));
      for (int c = 0; c < 8; c++) begin
         b[8+2*c] = 8'(delays >> (16*c + 8));
         b[9+2*c] = 8'(delays >> (16*c));
      end
      for (int i = 1; i < 24; i++) sum += int'(b[i]);
      b[24] = 8'(sum % 256);
      for (int i = 0; i < 25; i++) exp_q.push_back(b[i]);
   endfunction

   // uart_transmit model: ready falls one cycle after a strobe, back after 10
   initial begin
      uart.uart_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (uart.uart_send === 1'b1 && !stuck) begin
            @(negedge clk);
            uart.uart_ready = 1'b0;
            repeat (10) @(negedge clk);
            uart.uart_ready = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (uart.uart_send === 1'b1) begin
            nstrobe++;
            last_strobe = cyc;
            if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
            else check("byte", uart.uart_data, exp_q.pop_front());
         end
         if (done === 1'b1) done_cnt++;
         if (error === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
         end
      end
   end

   task automatic randomize_cfg();
      channel_select = 8'($urandom);
      aline_select   = 5'($urandom);
      pulse_shape    = $urandom;
      delays         = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic issue_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle_bound"}, n < 3000, 1);
   endtask

   task automatic wait_strobes(string name, int k);
      int n = 0;
      while (nstrobe < k && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_strobe_bound"}, n < 3000, 1);
   endtask

   task automatic run_full(string name, bit scramble);
      int d0 = done_cnt;
      nstrobe = 0;
      push_frame();
      issue_start();
      if (scramble) randomize_cfg();
      check({name, "_busy"}, busy, 1);
      wait_idle(name);
      repeat (3) @(negedge clk);
      check({name, "_done"}, done_cnt - d0, 1);
      check({name, "_strobes"}, nstrobe, 25);
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_busy_end"}, busy, 0);
   endtask

   initial begin
      int d0, e0;
      #1;
      check("reset_outs", {uart.uart_send, uart.uart_data, busy, done, error}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_outs", {uart.uart_send, uart.uart_data, busy, done, error}, 0);

      // all-zero config
      run_full("zero", 1'b0);

      // fixed pattern config
      channel_select = 8'hFF;
      aline_select   = 5'd31;
      pulse_shape    = 32'h12345678;
      for (int n = 0; n < 8; n++) delays[16*n +: 16] = 16'(16'h0101 * n);
      run_full("pattern", 1'b0);

      // inputs scrambled right after acceptance
      for (int r = 0; r < 3; r++) begin
         randomize_cfg();
         run_full("snapshot", 1'b1);
      end

      // abort while idx 5 is on the wire
      randomize_cfg();
      d0 = done_cnt;
      nstrobe = 0;
      push_frame();
      issue_start();
      wait_strobes("abort", 6);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle("abort");
      repeat (20) @(negedge clk);
      check("abort_strobes", nstrobe, 6);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_left", exp_q.size(), 19);
      check("abort_busy", busy, 0);
      exp_q.delete();
      randomize_cfg();
      run_full("after_abort", 1'b0);

      // ready never falls: timeout
      stuck = 1'b1;
      d0 = done_cnt;
      e0 = err_cnt;
      nstrobe = 0;
      push_frame();
      issue_start();
      wait_idle("timeout");
      repeat (5) @(negedge clk);
      check("timeout_err", err_cnt - e0, 1);
      check("timeout_delay", err_cyc - last_strobe, READY_TIMEOUT + 1);
      check("timeout_no_done", done_cnt - d0, 0);
      check("timeout_strobes", nstrobe, 1);
      check("timeout_busy", busy, 0);
      exp_q.delete();
      stuck = 1'b0;

      // reset mid-frame at idx 12
      randomize_cfg();
      nstrobe = 0;
      push_frame();
      issue_start();
      wait_strobes("rst", 13);
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      e0 = err_cnt;
      #2;
      rst_n = 1'b0;
      start = 1'b1;
      #1;
      check("rst_async", {uart.uart_send, uart.uart_data, busy, done, error}, 0);
      repeat (3) @(negedge clk);
      check("rst_start_ignored", busy, 0);
      start = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      randomize_cfg();
      run_full("after_rst", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
